// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, pc} holding buffer for words acked during an ID stall
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               full_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q  <= 1'b0;
            instr_q <= INSTR_W'(BUBBLE_INSTR);
            pc_q    <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - LEGv8 IF stage: owns the PC, talks req/ack to imem, feeds IF/ID
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_id,
    input  logic               br_taken_id,
    input  logic [ADDR_W-1:0]  br_target_id,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_if,
    output logic [ADDR_W-1:0]  pc_if,
    output logic [ADDR_W-1:0]  BLT_if,
    output logic               valid_if
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [ADDR_W-1:0]  blt_q, blt_d;
    logic               valid_q, valid_d;

    logic               skid_load, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic [ADDR_W-1:0]  target, pc_next;

    assign target  = br_target_id & ~ADDR_W'(3);
    assign pc_next = pc_q + ADDR_W'(PC_INC);

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .instr_i(imem_rdata),
        .pc_i   (pc_q),
        .full_o (skid_full),
        .instr_o(skid_instr),
        .pc_o   (skid_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            instr_q      <= INSTR_W'(BUBBLE_INSTR);
            pc_out_q     <= '0;
            blt_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            blt_q        <= blt_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        blt_d        = blt_q;
        valid_d      = valid_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (br_taken_id) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    // An un-acked request cannot be withdrawn, so it must be drained first.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (stall_id) begin
                    if (imem_ack) begin
                        skid_load = 1'b1;
                        pc_d      = pc_next;
                        state_d   = BUF;
                    end
                end else if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    blt_d    = pc_next;
                    valid_d  = 1'b1;
                    pc_d     = pc_next;
                end else begin
                    valid_d = 1'b0;
                end
            end
            BUF: begin
                if (br_taken_id) begin
                    skid_clear = 1'b1;
                    pc_d       = target;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end else if (!stall_id && skid_full) begin
                    skid_clear = 1'b1;
                    instr_d    = skid_instr;
                    pc_out_d   = skid_pc;
                    blt_d      = skid_pc + ADDR_W'(PC_INC);
                    valid_d    = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (br_taken_id) pc_d = target;
                if (br_taken_id || !stall_id) valid_d = 1'b0;
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req  = (state_q != BUF);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign instr_if  = instr_q;
    assign pc_if     = pc_out_q;
    assign BLT_if    = blt_q;
    assign valid_if  = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_id = 1'b0;
    logic        br_taken_id = 1'b0;
    logic [63:0] br_target_id = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, w_imem_req;
    logic [63:0] imem_addr, w_imem_addr;
    logic [31:0] instr_if, w_instr_if;
    logic [63:0] pc_if, w_pc_if, BLT_if, w_BLT_if;
    logic        valid_if, w_valid_if;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;
    exp_t sb_q[$];

    logic        mon_en = 1'b1;
    logic        last_valid = 1'b0;
    logic [63:0] last_pc = '0;

    always #5 clk = ~clk;

    fetch_unit u0 (
        .clk(clk), .reset(reset), .stall_id(stall_id), .br_taken_id(br_taken_id),
        .br_target_id(br_target_id), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_if(instr_if),
        .pc_if(pc_if), .BLT_if(BLT_if), .valid_if(valid_if)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u1 (
        .clk(clk), .reset(reset), .stall_id(stall_id), .br_taken_id(br_taken_id),
        .br_target_id(br_target_id), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_if(w_instr_if),
        .pc_if(w_pc_if), .BLT_if(w_BLT_if), .valid_if(w_valid_if)
    );

    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the bench's imem acking the request it expects at addr.
    task automatic ack_at(input logic [63:0] addr, input bit expect_accept);
        chk("ack_addr", imem_addr, addr);
        chk("ack_req", {63'h0, imem_req}, 64'd1);
        imem_ack   = 1'b1;
        imem_rdata = mem(addr);
        if (expect_accept) sb_q.push_back('{instr: mem(addr), pc: addr});
        tick();
        imem_ack = 1'b0;
    endtask

    // Output-register monitor: every new valid word is popped against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && valid_if && (!last_valid || pc_if != last_pc)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", pc_if, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr", {32'h0, instr_if}, {32'h0, e.instr});
                chk("sb_pc", pc_if, e.pc);
                chk("sb_blt", BLT_if, e.pc + 64'd4);
            end
        end
        last_valid = valid_if;
        last_pc    = pc_if;
    end

    initial begin
        // Reset state
        #2;
        chk("rst_req", {63'h0, imem_req}, 64'd1);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'h0, valid_if}, 64'd0);
        chk("rst_pc_if", pc_if, 64'h0);
        chk("rst_blt", BLT_if, 64'h0);
        chk("rst_instr", {32'h0, instr_if}, 64'h0);
        tick();
        tick();
        reset = 1'b0;
        chk("post_rst_addr", imem_addr, 64'h0);

        // Back-to-back acks
        for (int i = 0; i < 4; i++) begin
            ack_at(64'(i * 4), 1'b1);
            chk("b2b_valid", {63'h0, valid_if}, 64'd1);
            chk("b2b_pc", pc_if, 64'(i * 4));
        end
        chk("b2b_blt_last", BLT_if, 64'd16);

        // Three-cycle imem latency
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) begin
                tick();
                chk("slow_bubble", {63'h0, valid_if}, 64'd0);
                chk("slow_addr_held", imem_addr, 64'(16 + r * 4));
            end
            ack_at(64'(16 + r * 4), 1'b1);
            chk("slow_valid", {63'h0, valid_if}, 64'd1);
        end

        // Stall while an ack lands: word goes to the skid buffer
        stall_id = 1'b1;
        ack_at(64'd24, 1'b1);
        chk("stall_req_off", {63'h0, imem_req}, 64'd0);
        chk("stall_hold_pc", pc_if, 64'd20);
        tick();
        chk("stall2_req_off", {63'h0, imem_req}, 64'd0);
        chk("stall2_hold_pc", pc_if, 64'd20);
        chk("stall2_valid", {63'h0, valid_if}, 64'd1);
        stall_id = 1'b0;
        tick();
        chk("unstall_pc", pc_if, 64'd24);
        chk("unstall_next_addr", imem_addr, 64'd28);

        // Redirect with a request outstanding: drain it first
        br_taken_id  = 1'b1;
        br_target_id = 64'h103;
        tick();
        br_taken_id = 1'b0;
        chk("br_kill_valid", {63'h0, valid_if}, 64'd0);
        chk("drain_addr", imem_addr, 64'd28);
        for (int w = 0; w < 2; w++) begin
            tick();
            chk("drain_addr_held", imem_addr, 64'd28);
            chk("drain_req", {63'h0, imem_req}, 64'd1);
        end
        ack_at(64'd28, 1'b0);
        chk("drain_done_addr", imem_addr, 64'h100);
        chk("drain_drop_valid", {63'h0, valid_if}, 64'd0);
        ack_at(64'h100, 1'b1);
        chk("redirect_pc", pc_if, 64'h100);

        // Redirect coinciding with an ack: no drain, data discarded
        br_taken_id  = 1'b1;
        br_target_id = 64'h40;
        ack_at(64'h104, 1'b0);
        br_taken_id = 1'b0;
        chk("br_ack_valid", {63'h0, valid_if}, 64'd0);
        chk("br_ack_addr", imem_addr, 64'h40);
        chk("br_ack_req", {63'h0, imem_req}, 64'd1);
        ack_at(64'h40, 1'b1);
        ack_at(64'h44, 1'b1);
        chk("br_ack_pc", pc_if, 64'h44);

        // Reset mid-drain
        br_taken_id  = 1'b1;
        br_target_id = 64'h80;
        tick();
        br_taken_id = 1'b0;
        chk("pre_rst_drain_addr", imem_addr, 64'h48);
        mon_en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc_if", pc_if, 64'h0);
        chk("mid_rst_blt", BLT_if, 64'h0);
        chk("mid_rst_instr", {32'h0, instr_if}, 64'h0);
        chk("mid_rst_addr", imem_addr, 64'h0);
        chk("mid_rst_req", {63'h0, imem_req}, 64'd1);
        tick();
        reset = 1'b0;

        // PC wrap on the instance reset to the top word
        chk("wrap_addr0", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = mem(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_pc0", w_pc_if, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_blt0", w_BLT_if, 64'h0);
        chk("wrap_instr0", {32'h0, w_instr_if}, 64'h0000_0000_C0DE_FFFC);
        chk("wrap_addr1", w_imem_addr, 64'h0);
        imem_rdata = mem(64'h0);
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc1", w_pc_if, 64'h0);
        chk("wrap_blt1", w_BLT_if, 64'd4);
        chk("wrap_valid", {63'h0, w_valid_if}, 64'd1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined LEGv8 CPU, directly upstream of the IF/ID register.
- Owns the PC and issues requests to instruction memory over a req/ack handshake; imem may take multiple cycles.
- Presents registered {instr, pc, pc+4} plus a valid bit to IF/ID.
- Honours ID-stage stalls and branch redirects, and drains any in-flight imem request that a redirect makes stale.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_id  in  1  ID stage cannot accept a new instruction (load-use hazard); hold outputs.
- br_taken_id  in  1  branch resolved taken in ID; redirect fetch.
- br_target_id  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid for current request.
- imem_rdata  in  INSTR_W  fetched instruction.
- instr_if  out  INSTR_W  instruction to IF/ID.
- pc_if  out  ADDR_W  PC of instr_if (drives IF/ID pc).
- BLT_if  out  ADDR_W  pc_if+4, the BL link value.
- valid_if  out  1  instr_if is a real instruction; 0 means bubble.

Behaviour:
- Reset (async): pc_q=RESET_PC, state=FETCH, skid buffer empty, instr_if=0, pc_if=0, BLT_if=0, valid_if=0.
  - imem_req=1 with imem_addr=RESET_PC is visible combinationally during and right after reset.
- Reset mid-transaction abandons the outstanding request; imem must tolerate this.
- imem_req is 1 in FETCH and DRAIN, 0 in BUF.
  - imem_addr = pc_q in FETCH; = drain_addr in DRAIN.
- Output-register load: "accept" = instr_if<=imem_rdata (or buffered word), pc_if<=fetch address, BLT_if<=fetch address+4, valid_if<=1.
- Arithmetic: PC increments by 4 modulo 2^ADDR_W; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Latency: ack at edge N gives valid output after edge N. Back-to-back acks sustain 1 instr/cycle.
- FETCH state:
  - br_taken_id: pc_q<=target, valid_if<=0.
    - If ack the same cycle: data discarded, stay FETCH.
    - Else: drain_addr<=pc_q, go DRAIN.
  - ack & !stall_id: accept, pc_q<=pc_q+4, stay.
  - ack & stall_id: skid<={rdata, pc_q}, pc_q<=pc_q+4, outputs hold, go BUF.
  - no ack & !stall_id: valid_if<=0 (bubble); other outputs hold.
  - no ack & stall_id: all outputs hold.
- BUF state (no request outstanding):
  - br_taken_id: discard skid, pc_q<=target, valid_if<=0, go FETCH.
  - !stall_id: accept from skid, go FETCH.
  - else: hold.
- DRAIN state (stale request outstanding; a request may not be withdrawn before its ack):
  - Keep imem_req=1 with drain_addr.
  - On ack: discard data, go FETCH using pc_q.
  - Another br_taken_id while draining: pc_q<=new target; stay DRAIN.
  - valid_if<=0 while !stall_id.
- Priority: reset > br_taken_id > stall_id > ack.
- A redirect always kills the instruction in the output register.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, BUF, DRAIN}.
  - PC_INC = 4.
  - BUBBLE_INSTR = 32'h0.
- Sub-module fetch_skid_buf:
  - one-entry {instr, pc} buffer with load/clear/full and async reset.
- FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset release, imem acks every cycle, no stall → imem_addr 0,4,8,12; pc_if 0,4,8 on consecutive cycles; BLT_if 4,8,12; valid_if=1 from first ack+1.
- imem ack delayed 3 cycles per request → valid_if low for 3 cycles between instructions; imem_addr held constant during each wait.
- stall_id high 2 cycles while ack arrives for pc=8 → outputs hold pc_if=4; enters BUF with imem_req=0; after stall drops, pc_if=8 with buffered instr; next imem_addr=12.
- br_taken_id with target 0x103 while request for 0x10 outstanding → valid_if=0 next cycle; DRAIN keeps addr 0x10 until ack, data dropped; then imem_addr=0x100.
- br_taken_id and imem_ack in the same cycle in FETCH (target 0x40) → acked data never appears on instr_if; next imem_addr=0x40, no DRAIN.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, continuous acks → pc_if ...FFFC then 0; BLT_if for ...FFFC is 0. Reset asserted mid-DRAIN → outputs zero immediately, state FETCH at RESET_PC.
